// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: PHT entry layout, the post-reset
// entry value, and the PC -> table index / BTB tag slicing used by both the
// fetch-side predictor and the update unit.
package bpu_pkg;

  localparam int ENTRY_W = 10;
  localparam int HIST_HI = 9;
  localparam int HIST_LO = 8;

  typedef logic [ENTRY_W-1:0] pht_entry_t;

  // Weak not-taken in all four counters, local history 00.
  localparam pht_entry_t INIT_ENTRY = 10'b00_01010101;

  // Low bit of 2-bit counter k inside an entry.
  function automatic int ctr_lo(input int k);
    return 2 * k;
  endfunction

  // Table index: pc[depth+2:3] (pc[2] picks the slot inside a line).
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int depth);
    return (pc >> 3) & ((64'd1 << depth) - 64'd1);
  endfunction

  // BTB tag: the width bits sitting directly above the index.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int depth,
                                         input int width);
    return (pc >> (depth + 3)) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/pht_entry_update.sv
// Pure combinational PHT entry update: the counter selected by the entry's
// local history moves one step toward the actual direction (saturating at
// 0 and 3) and the outcome is shifted into the history.
module pht_entry_update
  import bpu_pkg::*;
(
  input  pht_entry_t entry_i,
  input  logic       taken_i,
  output pht_entry_t entry_o
);

  logic [1:0] hist;
  logic [1:0] ctr;
  logic [1:0] ctr_nxt;

  // Select, step and reinsert the history-addressed counter.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first,
    // otherwise synthesis infers a latch to hold the old value.
    hist = entry_i[HIST_HI:HIST_LO];
    ctr  = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (hist == 2'(k)) ctr = entry_i[ctr_lo(k) +: 2];
    end

    if (taken_i) ctr_nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else         ctr_nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;

    entry_o = entry_i;
    for (int k = 0; k < 4; k++) begin
      if (hist == 2'(k)) entry_o[ctr_lo(k) +: 2] = ctr_nxt;
    end
    entry_o[HIST_HI:HIST_LO] = {hist[0], taken_i};
  end

endmodule

// File: rtl/predict_update_unit.sv
// Branch predictor write side. Clears the PHT/BTB after reset (INIT), then
// accepts one resolved EX op per cycle (RUN). Cycle T: index the PHT and
// register the op. Cycle T+1: write the updated PHT entry / BTB target and
// pulse ex_wrong + redirect on a mispredict. An op whose line/slot is being
// written while it reads takes the in-flight write data instead of pht_rdata,
// so back-to-back updates to one entry compound.
// Optional: define BPU_STATS_EN to add stat_br_cnt / stat_miss_cnt.
module predict_update_unit
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int HASH_DEPTH = 5,
  parameter int HASH_WIDTH = 24,
  parameter int PARA_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_vld,
  output logic                    ex_ready,
  input  logic [ADDR_WIDTH-1:0]   ex_pc,
  input  logic                    ex_is_br,
  input  logic                    ex_taken,
  input  logic [ADDR_WIDTH-1:0]   ex_target,
  input  logic                    ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0]   ex_pred_pc,
  output logic [HASH_DEPTH-1:0]   pht_raddr,
  input  logic [2*PARA_WIDTH-1:0] pht_rdata,
  output logic [1:0]              pht_we,
  output logic [HASH_DEPTH-1:0]   pht_waddr,
  output logic [PARA_WIDTH-1:0]   pht_wdata,
  output logic [1:0]              btb_we,
  output logic [HASH_WIDTH-1:0]   btb_wtag,
  output logic [ADDR_WIDTH-1:0]   btb_wtarget,
  output logic                    ex_wrong,
  output logic                    redirect_vld,
  output logic [ADDR_WIDTH-1:0]   redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]             stat_br_cnt,
  output logic [31:0]             stat_miss_cnt
`endif
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [HASH_DEPTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_wr_q, init_wr_d;
  logic [1:0]            pht_we_q, pht_we_d;
  logic [HASH_DEPTH-1:0] pht_waddr_q, pht_waddr_d;
  logic                  upd_taken_q, upd_taken_d;
  logic                  fwd_vld_q, fwd_vld_d;
  pht_entry_t            fwd_entry_q, fwd_entry_d;
  logic [1:0]            btb_we_q, btb_we_d;
  logic [HASH_WIDTH-1:0] btb_wtag_q, btb_wtag_d;
  logic [ADDR_WIDTH-1:0] btb_wtarget_q, btb_wtarget_d;
  logic                  ex_wrong_q, ex_wrong_d;
  logic                  redirect_vld_q, redirect_vld_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic                  accept;
  logic [HASH_DEPTH-1:0] ex_idx;
  logic [HASH_WIDTH-1:0] ex_tag;
  logic [1:0]            ex_slot_mask;
  logic [ADDR_WIDTH-1:0] correct_next;
  logic                  mispredict;
  pht_entry_t            base_entry;
  pht_entry_t            upd_entry;

  assign ex_ready     = (state_q == ST_RUN);
  assign accept       = ex_vld & ex_ready;
  assign ex_idx       = HASH_DEPTH'(pc_index(64'(ex_pc), HASH_DEPTH));
  assign ex_tag       = HASH_WIDTH'(pc_tag(64'(ex_pc), HASH_DEPTH, HASH_WIDTH));
  // Slot 1 (pc[2] = 0) is the upper half of each line and we bit 1.
  assign ex_slot_mask = ex_pc[2] ? 2'b01 : 2'b10;
  assign correct_next = ex_taken ? ex_target : ex_pc + ADDR_WIDTH'(4);
  assign mispredict   = (ex_pred_taken != ex_taken) | (ex_pred_pc != correct_next);
  assign pht_raddr    = ex_idx;

  // Entry being updated this cycle: forwarded in-flight write, else table data.
  always_comb begin
    if (fwd_vld_q)        base_entry = fwd_entry_q;
    else if (pht_we_q[1]) base_entry = pht_rdata[2*PARA_WIDTH-1:PARA_WIDTH];
    else                  base_entry = pht_rdata[PARA_WIDTH-1:0];
  end

  pht_entry_update u_entry_update (
    .entry_i (base_entry),
    .taken_i (upd_taken_q),
    .entry_o (upd_entry)
  );

  // Write data is formed in the write cycle, once the old entry is available.
  always_comb begin
    if (init_wr_q)     pht_wdata = INIT_ENTRY;
    else if (|pht_we_q) pht_wdata = upd_entry;
    else               pht_wdata = '0;
  end

  // Next-state: init sweep, or register an accepted op for its T+1 effects.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_wr_d      = 1'b0;
    pht_we_d       = 2'b00;
    pht_waddr_d    = pht_waddr_q;
    upd_taken_d    = upd_taken_q;
    fwd_vld_d      = 1'b0;
    fwd_entry_d    = fwd_entry_q;
    btb_we_d       = 2'b00;
    btb_wtag_d     = btb_wtag_q;
    btb_wtarget_d  = btb_wtarget_q;
    ex_wrong_d     = 1'b0;
    redirect_vld_d = 1'b0;
    redirect_pc_d  = redirect_pc_q;

    if (state_q == ST_INIT) begin
      init_wr_d   = 1'b1;
      pht_we_d    = 2'b11;
      pht_waddr_d = init_cnt_q;
      if (init_cnt_q == '1) state_d = ST_RUN;
      else                  init_cnt_d = init_cnt_q + HASH_DEPTH'(1);
    end else if (accept) begin
      if (ex_is_br) begin
        pht_we_d    = ex_slot_mask;
        pht_waddr_d = ex_idx;
        upd_taken_d = ex_taken;
        // The table returns pre-write data when a read meets a write to the
        // same entry, so capture the write data for this op instead.
        fwd_vld_d   = (|(pht_we_q & ex_slot_mask)) && (pht_waddr_q == ex_idx);
        fwd_entry_d = pht_wdata;
        if (ex_taken) begin
          btb_we_d      = ex_slot_mask;
          btb_wtag_d    = ex_tag;
          btb_wtarget_d = {ex_target[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      if (mispredict) begin
        ex_wrong_d     = 1'b1;
        redirect_vld_d = 1'b1;
        redirect_pc_d  = correct_next;
      end
    end
  end

  // State registers; reset drops any pending op and restarts the init sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= '0;
      init_wr_q      <= 1'b0;
      pht_we_q       <= 2'b00;
      pht_waddr_q    <= '0;
      upd_taken_q    <= 1'b0;
      fwd_vld_q      <= 1'b0;
      fwd_entry_q    <= '0;
      btb_we_q       <= 2'b00;
      btb_wtag_q     <= '0;
      btb_wtarget_q  <= '0;
      ex_wrong_q     <= 1'b0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      init_wr_q      <= init_wr_d;
      pht_we_q       <= pht_we_d;
      pht_waddr_q    <= pht_waddr_d;
      upd_taken_q    <= upd_taken_d;
      fwd_vld_q      <= fwd_vld_d;
      fwd_entry_q    <= fwd_entry_d;
      btb_we_q       <= btb_we_d;
      btb_wtag_q     <= btb_wtag_d;
      btb_wtarget_q  <= btb_wtarget_d;
      ex_wrong_q     <= ex_wrong_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign pht_we       = pht_we_q;
  assign pht_waddr    = pht_waddr_q;
  assign btb_we       = btb_we_q;
  assign btb_wtag     = btb_wtag_q;
  assign btb_wtarget  = btb_wtarget_q;
  assign ex_wrong     = ex_wrong_q;
  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign br_cnt_d   = br_cnt_q + 32'(accept & ex_is_br);
  assign miss_cnt_d = miss_cnt_q + 32'(ex_wrong_q);

  // Event counters; no accepts and no mispredict pulses occur during INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign stat_br_cnt   = br_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule
